// File: rtl/evt_rate_pkg.sv
// Shared types and defaults for the round-robin event rate scheduler.
package evt_rate_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, HOLD} sched_state_t;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/sat_evt_counter.sv
// Saturating event counter with synchronous clear; sat_out is sticky once an event is dropped at max.
module sat_evt_counter
  import evt_rate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             en_in,
  input  logic             evt_in,
  output logic [CNT_W-1:0] count_out,
  output logic             sat_out
);
  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_out <= '0;
      sat_out   <= 1'b0;
    end else if (clear_in) begin
      count_out <= '0;
      sat_out   <= 1'b0;
    end else if (en_in && evt_in) begin
      if (count_out == MAX) sat_out <= 1'b1;
      else                  count_out <= count_out + 1'b1;
    end
  end
endmodule

// File: rtl/evt_rate_sched.sv
// Time-shares one saturating counter across N_CH event inputs, one fixed window per channel,
// and hands each finished count out over a valid/ready port.
module evt_rate_sched
  import evt_rate_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int WINDOW_CYCLES = 100000,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic [N_CH-1:0]         evt_in,
  output logic [CNT_W-1:0]        result_out,
  output logic [$clog2(N_CH)-1:0] result_ch_out,
  output logic                    result_overflow_out,
  output logic                    result_valid_out,
  input  logic                    result_ready_in,
  output logic                    busy_out
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;

  sched_state_t     state;
  logic [CH_W-1:0]  ch;
  logic [WIN_W-1:0] win;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  assign hit = (state == COUNT) && evt_in[ch];

  sat_evt_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_in  (state == CLEAR),
    .en_in     (state == COUNT),
    .evt_in    (evt_in[ch]),
    .count_out (cnt),
    .sat_out   (sat)
  );

  // The last window cycle's event lands in the counter at the same edge the result is
  // captured, so the result takes the counter's next value rather than its current one.
  assign cnt_nxt = (hit && cnt != MAX) ? cnt + 1'b1 : cnt;
  assign ovf_nxt = sat | (hit && cnt == MAX);

  assign busy_out = (state != IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state               <= IDLE;
      ch                  <= '0;
      win                 <= '0;
      result_out          <= '0;
      result_ch_out       <= '0;
      result_overflow_out <= 1'b0;
      result_valid_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable_in) state <= CLEAR;
        CLEAR: begin
          win <= WIN_W'(WINDOW_CYCLES - 1);
          state <= enable_in ? COUNT : IDLE;
        end
        COUNT: begin
          // Abort wins over window end: no result, pointer untouched.
          if (!enable_in) begin
            state <= IDLE;
          end else if (win == '0) begin
            result_out          <= cnt_nxt;
            result_overflow_out <= ovf_nxt;
            result_ch_out       <= ch;
            result_valid_out    <= 1'b1;
            state               <= HOLD;
          end else begin
            win <= win - 1'b1;
          end
        end
        HOLD: if (result_ready_in) begin
          result_valid_out <= 1'b0;
          ch    <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
          state <= enable_in ? CLEAR : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_evt_rate_sched.sv
// Directed bench: two instances (10-cycle/16-bit and 20-cycle/4-bit) with hand-computed results.
module tb_evt_rate_sched;
  logic        clk_in = 1'b0;
  logic        rst, en, rdy, vld, busy, ovf, rch;
  logic [1:0]  evt;
  logic [15:0] res;
  logic        s_rst, s_en, s_rdy, s_vld, s_busy, s_ovf, s_rch;
  logic [1:0]  s_evt;
  logic [3:0]  s_res;
  int errs = 0;
  int nchk = 0;
  int n;

  always #5 clk_in = ~clk_in;

  evt_rate_sched #(.N_CH(2), .WINDOW_CYCLES(10), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst), .enable_in(en), .evt_in(evt),
    .result_out(res), .result_ch_out(rch), .result_overflow_out(ovf),
    .result_valid_out(vld), .result_ready_in(rdy), .busy_out(busy)
  );

  evt_rate_sched #(.N_CH(2), .WINDOW_CYCLES(20), .CNT_W(4)) dut_s (
    .clk_in(clk_in), .rst_in(s_rst), .enable_in(s_en), .evt_in(s_evt),
    .result_out(s_res), .result_ch_out(s_rch), .result_overflow_out(s_ovf),
    .result_valid_out(s_vld), .result_ready_in(s_rdy), .busy_out(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Tick until the chosen instance raises valid; n is the number of edges taken.
  task automatic wait_vld(input bit s, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(s ? s_vld : vld) && cyc < 60);
    if (!(s ? s_vld : vld)) chk("vld_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_res(input string tag, input int c, input int r, input int o);
    chk({tag, "_ch"},  32'(rch), 32'(c));
    chk({tag, "_res"}, 32'(res), 32'(r));
    chk({tag, "_ovf"}, 32'(ovf), 32'(o));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; rdy = 1'b1; evt = 2'b01;
    s_rst = 1'b0; s_en = 1'b0; s_rdy = 1'b1; s_evt = 2'b01;
    #2;
    rst = 1'b1; s_rst = 1'b1;
    tick(); tick();
    chk("rst_vld", 32'(vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res", 32'(res), 0);
    chk("rst_ch", 32'(rch), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0; s_rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // basic: ch0 sees 10 events, ch1 none, 12 edges to valid
    en = 1'b1;
    wait_vld(1'b0, n);
    chk("lat", 32'(n), 12);
    chk_res("r1", 0, 10, 0);
    tick();
    chk("r1_vld_drop", 32'(vld), 0);
    chk("r1_busy", 32'(busy), 1);
    wait_vld(1'b0, n);
    chk("period", 32'(n), 11);
    chk_res("r2", 1, 0, 0);
    tick();
    rdy = 1'b0;

    // backpressure on ch0 result while evt toggles
    wait_vld(1'b0, n);
    chk_res("r3", 0, 10, 0);
    for (int i = 0; i < 5; i++) begin
      evt = (i % 2 == 0) ? 2'b00 : 2'b11;
      tick();
      chk("bp_vld", 32'(vld), 1);
      chk("bp_res", 32'(res), 10);
      chk("bp_ch", 32'(rch), 0);
    end
    evt = 2'b01;
    rdy = 1'b1;
    tick();
    chk("bp_xfer", 32'(vld), 0);
    wait_vld(1'b0, n);
    chk_res("r4", 1, 0, 0);
    tick();
    rdy = 1'b0;

    // enable dropped in HOLD: result still delivered, then IDLE with pointer at 1
    wait_vld(1'b0, n);
    chk_res("r5", 0, 10, 0);
    en = 1'b0;
    tick();
    chk("enh_vld", 32'(vld), 1);
    chk("enh_busy", 32'(busy), 1);
    rdy = 1'b1;
    tick();
    chk("enh_vld_drop", 32'(vld), 0);
    chk("enh_idle", 32'(busy), 0);
    tick();
    chk("enh_idle2", 32'(busy), 0);
    en = 1'b1;
    wait_vld(1'b0, n);
    chk_res("r6", 1, 0, 0);

    // abort at COUNT cycle 5 of ch0, then re-measure from zero
    tick();
    tick();
    repeat (4) tick();
    en = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vld", 32'(vld), 0);
    repeat (3) tick();
    chk("abort_vld2", 32'(vld), 0);
    en = 1'b1;
    wait_vld(1'b0, n);
    chk("abort_lat", 32'(n), 12);
    chk_res("r7", 0, 10, 0);

    // async reset mid-COUNT (ch1 window)
    tick();
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_vld", 32'(vld), 0);
    #3 rst = 1'b0;
    rdy = 1'b0;
    wait_vld(1'b0, n);
    chk_res("r8", 0, 10, 0);

    // async reset mid-HOLD
    tick(); tick();
    chk("hold_vld", 32'(vld), 1);
    #2 rst = 1'b1;
    #1;
    chk("hrst_vld", 32'(vld), 0);
    chk("hrst_res", 32'(res), 0);
    chk("hrst_busy", 32'(busy), 0);
    #3 rst = 1'b0;
    en = 1'b0;

    // saturation: 20 events into a 4-bit counter
    s_en = 1'b1;
    wait_vld(1'b1, n);
    chk("sat_ch", 32'(s_rch), 0);
    chk("sat_res", 32'(s_res), 15);
    chk("sat_ovf", 32'(s_ovf), 1);
    wait_vld(1'b1, n);
    chk("sat1_ch", 32'(s_rch), 1);
    chk("sat1_res", 32'(s_res), 0);
    chk("sat1_ovf", 32'(s_ovf), 0);
    s_evt = 2'b00;
    tick();
    tick();
    s_evt = 2'b01;
    repeat (3) tick();
    s_evt = 2'b00;
    wait_vld(1'b1, n);
    chk("sat2_ch", 32'(s_rch), 0);
    chk("sat2_res", 32'(s_res), 3);
    chk("sat2_ovf", 32'(s_ovf), 0);
    s_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
